// File: rtl/sparse_mxv_tile_sched_pkg.sv
// rtl/sparse_mxv_tile_sched_pkg.sv - shared states, default sizes and result packing for the tile scheduler
package spmv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_OUT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int DEF_MAX_TILES  = 4;
  localparam int DEF_LOAD_BEATS = 64;
  localparam int DEF_PIPE_LAT   = 16;
  localparam int DEF_OUT_LEN    = 2048;

  // Engine 1 lands in the upper half of the result word.
  function automatic logic [31:0] pack_result(input logic [15:0] e0, input logic [15:0] e1);
    return {e1, e0};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sparse_mxv_tile_sched_if.sv
// rtl/sparse_mxv_tile_sched_if.sv - job control, BRAM and engine signals of the tile scheduler (perf counter under SPMV_SCHED_PERF_EN)
interface sparse_mxv_tile_sched_if #(
  parameter int IN_AW  = 8,
  parameter int OUT_AW = 13
);
  logic              start;
  logic              abort;
  logic [2:0]        num_tiles;
  logic [15:0]       one_elements0;
  logic [15:0]       one_elements1;
  logic              eng_idle;
  logic              eninput;
  logic [IN_AW-1:0]  input_addr;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [31:0]       out_data;
  logic              busy;
  logic              done;
  logic [1:0]        tile_idx;
`ifdef SPMV_SCHED_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  modport master (
    output start, abort, num_tiles, one_elements0, one_elements1,
    input  eng_idle, eninput, input_addr, out_we, out_addr, out_data, busy, done, tile_idx
`ifdef SPMV_SCHED_PERF_EN
    , input perf_cycles
`endif
  );

  modport slave (
    input  start, abort, num_tiles, one_elements0, one_elements1,
    output eng_idle, eninput, input_addr, out_we, out_addr, out_data, busy, done, tile_idx
`ifdef SPMV_SCHED_PERF_EN
    , output perf_cycles
`endif
  );

endinterface

// File: rtl/sparse_mxv_tile_sched_addr_gen.sv
// rtl/sparse_mxv_tile_sched_addr_gen.sv - tile-base multiply-add for input and result BRAM addresses
module spmv_addr_gen #(
  parameter int IN_AW      = 8,
  parameter int OUT_AW     = 13,
  parameter int LOAD_BEATS = 64,
  parameter int OUT_LEN    = 2048,
  parameter int CNT_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [1:0]        ld_tile,
  input  logic [CNT_W-1:0]  ld_k,
  input  logic              st_en,
  input  logic [1:0]        st_tile,
  input  logic [CNT_W-1:0]  st_k,
  output logic [IN_AW-1:0]  input_addr,
  output logic [OUT_AW-1:0] out_addr
);

  // Addresses only move while their phase is active and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_addr <= '0;
      out_addr   <= '0;
    end else begin
      if (ld_en) input_addr <= IN_AW'(int'(ld_tile) * LOAD_BEATS + int'(ld_k));
      if (st_en) out_addr   <= OUT_AW'(int'(st_tile) * OUT_LEN + int'(st_k));
    end
  end

endmodule

// File: rtl/sparse_mxv_tile_sched.sv
// rtl/sparse_mxv_tile_sched.sv - multi-tile clear/load/wait/drain scheduler for the dual sparse MxV engines (optional SPMV_SCHED_PERF_EN)
module sparse_mxv_tile_sched
  import spmv_pkg::*;
#(
  parameter int MAX_TILES  = DEF_MAX_TILES,
  parameter int LOAD_BEATS = DEF_LOAD_BEATS,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int OUT_LEN    = DEF_OUT_LEN,
  parameter int IN_AW      = 8,
  parameter int OUT_AW     = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  sparse_mxv_tile_sched_if.slave bus
);

  localparam int CNT_W = $clog2(max3(LOAD_BEATS, PIPE_LAT, OUT_LEN));

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       tiles, tiles_req;
  logic [1:0]       tile_idx;
  logic             start_ok;
  logic             last_tile;

  assign tiles_req = (bus.num_tiles > 3'(MAX_TILES)) ? 3'(MAX_TILES) : bus.num_tiles;
  assign start_ok  = (state == S_IDLE) && bus.start && !bus.abort;
  assign last_tile = (({1'b0, tile_idx} + 3'd1) >= tiles);

  // Next state and phase counter; the counter restarts at every state entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = (tiles_req == 3'd0) ? S_DONE : S_CLEAR;
      S_CLEAR: state_nxt = S_LOAD;
      S_LOAD:  if (cnt == CNT_W'(LOAD_BEATS - 1)) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(PIPE_LAT - 1)) state_nxt = S_OUT;
      S_OUT:   if (cnt == CNT_W'(OUT_LEN - 1)) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = last_tile ? S_DONE : S_CLEAR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
    if ((state_nxt == state) && (state != S_IDLE)) cnt_nxt = cnt + 1'b1;
  end

  // State register and phase counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Job tile count is latched at start; tile index advances in NEXT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tiles    <= '0;
      tile_idx <= '0;
    end else if (start_ok) begin
      tiles    <= tiles_req;
      tile_idx <= '0;
    end else if (bus.abort) begin
      tile_idx <= '0;
    end else if (state == S_NEXT) begin
      tile_idx <= tile_idx + 2'd1;
    end
  end

  // Write strobe and data are registered alongside out_addr; abort kills the in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_we   <= 1'b0;
      bus.out_data <= '0;
    end else begin
      bus.out_we <= (state == S_OUT) && !bus.abort;
      if (state == S_OUT) bus.out_data <= pack_result(bus.one_elements0, bus.one_elements1);
    end
  end

  spmv_addr_gen #(
    .IN_AW      (IN_AW),
    .OUT_AW     (OUT_AW),
    .LOAD_BEATS (LOAD_BEATS),
    .OUT_LEN    (OUT_LEN),
    .CNT_W      (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .ld_en      (state_nxt == S_LOAD),
    .ld_tile    (tile_idx),
    .ld_k       (cnt_nxt),
    .st_en      (state == S_OUT),
    .st_tile    (tile_idx),
    .st_k       (cnt),
    .input_addr (bus.input_addr),
    .out_addr   (bus.out_addr)
  );

  assign bus.eng_idle = (state == S_CLEAR);
  assign bus.eninput  = (state == S_LOAD);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.tile_idx = tile_idx;

`ifdef SPMV_SCHED_PERF_EN
  // Busy-cycle counter: restarts per job, holds when idle, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.perf_cycles <= '0;
    end else if (start_ok) begin
      bus.perf_cycles <= '0;
    end else if ((state != S_IDLE) && (bus.perf_cycles != 32'hFFFF_FFFF)) begin
      bus.perf_cycles <= bus.perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/sparse_mxv_tile_sched.md
# sparse_mxv_tile_sched

Tile scheduler for the dual sparse matrix-vector engine pair. For each tile of a multi-tile job it clears both engines, streams the activation vector from the input BRAM, waits out the engine pipeline, and writes both engines' result streams as packed words into the result BRAM. It replaces the single-pass sequencing in the engine wrapper with a restartable, multi-tile controller that software starts and monitors.

## Interface
- `MAX_TILES`, 4: largest tile count per job.
- `LOAD_BEATS`, 64: input BRAM reads per tile.
- `PIPE_LAT`, 16: cycles from the last load beat to the first valid engine output.
- `OUT_LEN`, 2048: result elements per engine per tile.
- `IN_AW`, 8: input BRAM address width; must satisfy 2^IN_AW ≥ MAX_TILES·LOAD_BEATS.
- `OUT_AW`, 13: result BRAM address width; must satisfy 2^OUT_AW ≥ MAX_TILES·OUT_LEN.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `abort` in 1: synchronous job cancel.
- `num_tiles` in 3: tile count; latched on an accepted `start`.
- `one_elements0` in 16: engine 0 result stream.
- `one_elements1` in 16: engine 1 result stream.
- `eng_idle` out 1: clear pulse to both engines.
- `eninput` out 1: input BRAM enable.
- `input_addr` out IN_AW: input BRAM address.
- `out_we` out 1: result BRAM write enable.
- `out_addr` out OUT_AW: result BRAM address.
- `out_data` out 32: packed result, `{one_elements1, one_elements0}`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job end.
- `tile_idx` out 2: current tile number.

## Operation
- State machine:
  - IDLE → CLEAR on `start`. The latched count is `min(num_tiles, MAX_TILES)`. If that count is 0, go IDLE → DONE directly with no engine or BRAM activity.
  - CLEAR (1 cycle): `eng_idle`=1.
  - LOAD (LOAD_BEATS cycles): `eninput`=1; `input_addr` = tile·LOAD_BEATS + k, for k = 0..LOAD_BEATS-1.
  - WAIT (PIPE_LAT cycles): all enables low.
  - OUT (OUT_LEN cycles): engine outputs are sampled each cycle k.
  - NEXT (1 cycle): increment `tile_idx`. Go to CLEAR if tiles remain, else DONE.
  - DONE (1 cycle): `done`=1, then IDLE.
- Result path:
  - `out_we`, `out_addr` = tile·OUT_LEN + k, and `out_data` are registered together.
  - Sample k is therefore written one cycle after its OUT cycle, and the last write of a tile lands in the NEXT cycle.
- `busy` is 1 in every state except IDLE. It is 0 in the cycle the FSM is back in IDLE.
- `start` while not in IDLE is ignored; it is neither queued nor does it restart the job.
- `abort` in any non-IDLE state:
  - Next cycle: state IDLE, all enables 0, no `done`.
  - A result write registered in the abort cycle is suppressed.
  - `abort` and `start` together in IDLE: `abort` wins; `start` is dropped.
- Reset mid-job: all outputs return to reset values immediately. Result BRAM contents are unspecified.
- Phase counter: a single counter, cleared on every state entry. Width is clog2(max(LOAD_BEATS, PIPE_LAT, OUT_LEN)). It never wraps inside a phase.

## Timing
- Reset values: all outputs 0; state IDLE; `tile_idx` 0.
- Cycle numbering: cycle 0 is the cycle `start` is high in IDLE.
- Default parameters, per tile (T = tile·2130):
  - CLEAR: cycle 1+T.
  - LOAD: cycles 2+T .. 65+T.
  - WAIT: cycles 66+T .. 81+T.
  - OUT: cycles 82+T .. 2129+T.
  - Writes visible: cycles 83+T .. 2130+T.
  - NEXT: cycle 2130+T.
- Tile period: 2130 cycles.
- `done` at cycle 2130·N + 1 for an N-tile job.
- Back-to-back jobs: next `start` accepted at cycle 2130·N + 2 at the earliest.
- `input_addr` and `out_addr` hold their last values outside LOAD and OUT; only the enables qualify them.

## Configuration
- `SPMV_SCHED_PERF_EN` defined:
  - Adds output `perf_cycles` (32 bits).
  - Cleared on an accepted `start`.
  - Increments every cycle while `busy`.
  - Holds after `done` or `abort`; saturates at 0xFFFF_FFFF.
- `SPMV_SCHED_PERF_EN` undefined: the port and the counter do not exist, and all other behaviour is identical.

## Structure
- Shared package `spmv_pkg`:
  - State enum (IDLE, CLEAR, LOAD, WAIT, OUT, NEXT, DONE).
  - Default constants LOAD_BEATS, PIPE_LAT, OUT_LEN.
  - Packing function for `out_data`.
- Sub-module `spmv_addr_gen`: tile-base multiply-add for `input_addr` and `out_addr`, with a registered output.
- FSM and phase counter stay in the top module.

## Test plan
- Single tile, `num_tiles`=1:
  - `eng_idle` at cycle 1.
  - `input_addr` 0..63 on cycles 2..65.
  - 2048 writes to addresses 0..2047 on cycles 83..2130.
  - `done` at cycle 2131.
- Three tiles, engines driving a ramp (`one_elements0` = k, `one_elements1` = ~k):
  - Tile 2 loads addresses 128..191 and writes addresses 4096..6143.
  - `out_data` at address 4096+k is `{~k, k}`.
- `num_tiles`=0: `done` at cycle 1; `eng_idle`, `eninput`, `out_we` never high.
- `num_tiles`=6: clamped to 4 tiles; last write to address 8191.
- `abort` at cycle 500:
  - Cycle 501 in IDLE: `busy`=0, `out_we`=0, no `done`.
  - A new `start` at 502 restarts from tile 0.
- `start` pulses at cycles 10 and 1000 during a job: both ignored, single `done`. Async `rst` at cycle 300 forces all outputs to 0 before the next edge.
